// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: one shared synchronous prescaler, per-channel off/on/blink/burst.
// Optional build macro LED_PWM_EN adds a per-channel brightness input cfg_bright.

module led_blink_chan #(
  parameter int SEL_WIDTH = 2,
  parameter int BURST_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [(1<<SEL_WIDTH)-1:0] taps,
`ifdef LED_PWM_EN
  input  logic [7:0]                cnt_lo,
  input  logic [7:0]                cfg_bright,
`endif
  input  logic                      wr,
  input  logic [1:0]                cfg_mode,
  input  logic [SEL_WIDTH-1:0]      cfg_rate,
  input  logic [BURST_W-1:0]        cfg_count,
  output logic                      led,
  output logic                      done,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, FIN} state_t;
  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BURST = 2'd3;

  state_t               state, state_n;
  logic [1:0]           mode, mode_n;
  logic [SEL_WIDTH-1:0] rate, rate_n;
  logic [BURST_W-1:0]   rem, rem_n;
  logic                 ptap, ptap_n;
  logic                 led_n, done_n, on_n;
  logic                 tap, new_tap, pwm_ok;

  // Taps are ordered fastest-first, so inverting rate selects slowest for rate=0.
  assign tap     = taps[~rate];
  assign new_tap = taps[~cfg_rate];

`ifdef LED_PWM_EN
  logic [7:0] bright, bright_n;
  assign pwm_ok = cnt_lo < bright;
`else
  assign pwm_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    mode_n  = mode;
    rate_n  = rate;
    rem_n   = rem;
    ptap_n  = tap;
    led_n   = led;
    done_n  = 1'b0;
    on_n    = 1'b0;
`ifdef LED_PWM_EN
    bright_n = bright;
`endif
    if (wr) begin
      // A write always wins: aborts any burst and swallows a coincident done.
      mode_n = cfg_mode;
      rate_n = cfg_rate;
      rem_n  = cfg_count;
      ptap_n = new_tap;
`ifdef LED_PWM_EN
      bright_n = cfg_bright;
`endif
      if (cfg_mode == M_BURST) begin
        if (cfg_count == '0) begin
          state_n = FIN;
          done_n  = 1'b1;
        end else begin
          state_n = ARM;
        end
      end else begin
        state_n = IDLE;
      end
    end else begin
      case (mode)
        M_OFF:   on_n = 1'b0;
        M_ON:    on_n = 1'b1;
        M_BLINK: on_n = tap;
        default: begin
          case (state)
            ARM: if (!ptap && tap) begin
              state_n = RUN;
              on_n    = 1'b1;
            end
            RUN: begin
              on_n = tap;
              if (ptap && !tap) begin
                rem_n = rem - 1'b1;
                if (rem == BURST_W'(1)) begin
                  state_n = FIN;
                  done_n  = 1'b1;
                end
              end
            end
            default: on_n = 1'b0;
          endcase
        end
      endcase
      led_n = on_n & pwm_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mode  <= M_OFF;
      rate  <= '0;
      rem   <= '0;
      ptap  <= 1'b0;
      led   <= 1'b0;
      done  <= 1'b0;
`ifdef LED_PWM_EN
      bright <= 8'hff;
`endif
    end else begin
      state <= state_n;
      mode  <= mode_n;
      rate  <= rate_n;
      rem   <= rem_n;
      ptap  <= ptap_n;
      led   <= led_n;
      done  <= done_n;
`ifdef LED_PWM_EN
      bright <= bright_n;
`endif
    end
  end

  assign busy = (state == ARM) || (state == RUN);
endmodule

module led_blink_ctrl #(
  parameter int NUM_LEDS  = 4,
  parameter int CNT_WIDTH = 27,
  parameter int SEL_WIDTH = 2,
  parameter int TAP_BASE  = 23,
  parameter int BURST_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_chan,
  input  logic [1:0]           cfg_mode,
  input  logic [SEL_WIDTH-1:0] cfg_rate,
  input  logic [BURST_W-1:0]   cfg_count,
`ifdef LED_PWM_EN
  input  logic [7:0]           cfg_bright,
`endif
  output logic                 cfg_err,
  output logic [NUM_LEDS-1:0]  led,
  output logic [NUM_LEDS-1:0]  done,
  output logic [NUM_LEDS-1:0]  busy
);
  localparam int NTAP = 1 << SEL_WIDTH;

  logic [CNT_WIDTH-1:0] cnt;
  logic [NTAP-1:0]      taps;
  logic                 acc;
  logic                 unused_cnt;

  assign cfg_ready  = ~reset;
  assign acc        = cfg_valid & cfg_ready;
  assign taps       = cnt[TAP_BASE +: NTAP];
  assign unused_cnt = ^cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      cfg_err <= acc && (32'(cfg_chan) >= NUM_LEDS);
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : gen_chan
    led_blink_chan #(
      .SEL_WIDTH (SEL_WIDTH),
      .BURST_W   (BURST_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .taps      (taps),
`ifdef LED_PWM_EN
      .cnt_lo    (cnt[7:0]),
      .cfg_bright(cfg_bright),
`endif
      .wr        (acc && (cfg_chan == 4'(i))),
      .cfg_mode  (cfg_mode),
      .cfg_rate  (cfg_rate),
      .cfg_count (cfg_count),
      .led       (led[i]),
      .done      (done[i]),
      .busy      (busy[i])
    );
  end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: expectations queued per cycle, compared at negedge.
module tb_led_blink_ctrl;
  localparam int NL = 4, CW = 8, SW = 2, TB = 4, BW = 8;

  logic          clk, reset, cfg_valid, cfg_ready, cfg_err;
  logic [3:0]    cfg_chan;
  logic [1:0]    cfg_mode;
  logic [SW-1:0] cfg_rate;
  logic [BW-1:0] cfg_count;
  logic [NL-1:0] led, done, busy;
`ifdef LED_PWM_EN
  logic [7:0]    cfg_bright;
`endif

  led_blink_ctrl #(.NUM_LEDS(NL), .CNT_WIDTH(CW), .SEL_WIDTH(SW), .TAP_BASE(TB), .BURST_W(BW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_rate(cfg_rate), .cfg_count(cfg_count),
`ifdef LED_PWM_EN
    .cfg_bright(cfg_bright),
`endif
    .cfg_err(cfg_err), .led(led), .done(done), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {string tag; int cyc; int fld; int ch; int val;} exp_t;
  localparam int F_LED = 0, F_DONE = 1, F_BUSY = 2, F_ERR = 3, F_RDY = 4;

  exp_t q[$];
  int   nchk = 0, nerr = 0;
  int   cyc = 0, mcnt = 0;

  // Reference prescaler, straight from the counter definition.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) mcnt <= 0;
    else       mcnt <= (mcnt + 1) % 256;
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int obs(input int f, input int ch);
    logic [15:0] v;
    case (f)
      F_LED:   v = 16'(led);
      F_DONE:  v = 16'(done);
      F_BUSY:  v = 16'(busy);
      F_ERR:   v = 16'(cfg_err);
      default: v = 16'(cfg_ready);
    endcase
    return (ch < 0) ? int'(v) : int'(v[ch]);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, obs(e.fld, e.ch), e.val);
    end
  end

  task automatic push(input string tag, input int c, input int f, input int ch, input int v);
    exp_t e;
    e.tag = tag; e.cyc = c; e.fld = f; e.ch = ch; e.val = v;
    q.push_back(e);
  endtask

  function automatic int cnt_at(input int j);
    return (mcnt + j - cyc) & 255;
  endfunction

  // With PWM built in, default brightness 255 darkens the phase registered at cnt=255.
  function automatic int pg(input int j);
`ifdef LED_PWM_EN
    return (cnt_at(j - 1) != 255) ? 1 : 0;
`else
    return (j == j) ? 1 : 1;
`endif
  endfunction

`ifdef LED_PWM_EN
  int bright_sel = 255;
`endif

  task automatic wr(input int ch, input int mode, input int rate, input int count);
    cfg_valid = 1'b1;
    cfg_chan  = 4'(ch);
    cfg_mode  = 2'(mode);
    cfg_rate  = SW'(rate);
    cfg_count = BW'(count);
`ifdef LED_PWM_EN
    cfg_bright = 8'(bright_sel);
`endif
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 5000) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (mcnt != v && n < 400) begin @(posedge clk); #1; n++; end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0; cfg_rate = '0; cfg_count = '0;
`ifdef LED_PWM_EN
    cfg_bright = 8'hff;
`endif
    // Reset held for three edges.
    repeat (3) begin
      @(posedge clk); #1;
      push("rst_led", cyc, F_LED, -1, 0);  push("rst_done", cyc, F_DONE, -1, 0);
      push("rst_busy", cyc, F_BUSY, -1, 0); push("rst_err", cyc, F_ERR, -1, 0);
      push("rst_rdy", cyc, F_RDY, -1, 0);
    end
    @(negedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    push("post_led", cyc, F_LED, -1, 0);  push("post_done", cyc, F_DONE, -1, 0);
    push("post_busy", cyc, F_BUSY, -1, 0); push("post_rdy", cyc, F_RDY, -1, 1);
    push("post_cnt1", cyc, F_LED, 0, 0);
    chk("cnt_at_release", mcnt, 1);

    // Blink: ch0 fastest tap (bit 4), ch1 slowest tap (bit 7).
    drain();
    wr(0, 2, 3, 0);
    wr(1, 2, 0, 0);
    for (int j = cyc; j < cyc + 300; j++) begin
      push("blink0", j, F_LED, 0, ((cnt_at(j - 1) >> 4) & 1) & pg(j));
      if (j > cyc) push("blink1", j, F_LED, 1, ((cnt_at(j - 1) >> 7) & 1) & pg(j));
      if (j % 16 == 0) begin
        push("blink_done", j, F_DONE, -1, 0);
        push("blink_busy", j, F_BUSY, -1, 0);
      end
    end

    // Burst of 3 on ch2 written at cnt=5.
    drain();
    wait_cnt(5);
    wr(2, 3, 3, 3);
    for (int v = 6; v <= 140; v++) begin
      int j;
      j = cyc + v - 6;
      push("burst_led", j, F_LED, 2, (v >= 17 && v <= 96) ? (((v - 1) >> 4) & 1) : 0);
      push("burst_done", j, F_DONE, 2, (v == 97) ? 1 : 0);
      push("burst_busy", j, F_BUSY, 2, (v <= 96) ? 1 : 0);
    end

    // Zero-count burst on ch3: immediate done.
    drain();
    wr(3, 3, 3, 0);
    push("zero_done", cyc, F_DONE, 3, 1);
    push("zero_busy", cyc, F_BUSY, 3, 0);
    push("ok_err", cyc, F_ERR, -1, 0);
    for (int j = cyc + 1; j <= cyc + 5; j++) begin
      push("zero_done_end", j, F_DONE, 3, 0);
      push("zero_led", j, F_LED, 3, 0);
    end

    // Abort a running burst with mode=on.
    drain();
    wr(2, 3, 3, 5);
    repeat (40) begin @(posedge clk); #1; end
    push("abort_pre_busy", cyc, F_BUSY, 2, 1);
    wr(2, 1, 0, 0);
    for (int j = cyc; j <= cyc + 20; j++) begin
      push("abort_done", j, F_DONE, 2, 0);
      push("abort_busy", j, F_BUSY, 2, 0);
      if (j > cyc) push("abort_led", j, F_LED, 2, pg(j));
    end

    // Write landing on the burst-completing edge: no done.
    drain();
    wait_cnt(5);
    wr(2, 3, 3, 1);
    wait_cnt(32);
    push("coin_pre_busy", cyc, F_BUSY, 2, 1);
    push("coin_pre_led", cyc, F_LED, 2, 1);
    wr(2, 0, 0, 0);
    for (int j = cyc; j <= cyc + 20; j++) begin
      push("coin_done", j, F_DONE, 2, 0);
      push("coin_busy", j, F_BUSY, 2, 0);
      if (j > cyc) push("coin_led", j, F_LED, 2, 0);
    end

    // Invalid channel.
    drain();
    wr(5, 1, 0, 0);
    push("bad_err", cyc, F_ERR, -1, 1);
    push("bad_err_end", cyc + 1, F_ERR, -1, 0);
    for (int j = cyc; j <= cyc + 2; j++) begin
      push("bad_led2", j, F_LED, 2, 0);
      push("bad_led3", j, F_LED, 3, 0);
      push("bad_done", j, F_DONE, -1, 0);
    end

    // Reset during a running burst.
    drain();
    wr(3, 3, 3, 4);
    repeat (40) begin @(posedge clk); #1; end
    push("mid_busy", cyc, F_BUSY, 3, 1);
    reset = 1'b1;
    push("mid_rdy", cyc, F_RDY, -1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    push("mid_rdy_up", cyc, F_RDY, -1, 1);
    for (int j = cyc; j <= cyc + 30; j++) begin
      push("mid_led", j, F_LED, -1, 0);
      push("mid_done", j, F_DONE, -1, 0);
      push("mid_busy0", j, F_BUSY, -1, 0);
    end
    drain();

`ifdef LED_PWM_EN
    begin
      int hi = 0;
      bright_sel = 64;
      wr(0, 1, 0, 0);
      repeat (2) begin @(posedge clk); #1; end
      repeat (256) begin @(negedge clk); hi += int'(led[0]); end
      chk("pwm_duty", hi, 64);
    end
`endif

    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
